// File: rtl/sw_job_scheduler_pkg.sv
// sw_job_scheduler_pkg: shared widths, FSM states, error codes and helpers
// for the Smith-Waterman job scheduler.
package sw_job_scheduler_pkg;
    localparam int MATCH_BIT     = 8;
    localparam int CALC_BIT      = 16;
    localparam int MAX_T_NUM_BIT = 12;
    localparam int SCHED_ID_BIT  = 4;
    localparam int CNT_BIT       = 16;

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, RUN, DONE} state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_NO_BUSY = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_BIT-1:0] sat_inc(input logic [CNT_BIT-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/sw_job_scheduler_if.sv
// sw_job_scheduler_if: job port, core control/result port and result-record
// port of the scheduler. Names carry the scheduler's direction (_i into it,
// _o out of it). slave = scheduler side, master = host/core side.
interface sw_job_scheduler_if;
    import sw_job_scheduler_pkg::*;
    logic                     job_valid_i;
    logic                     job_ready_o;
    logic [SCHED_ID_BIT-1:0]  job_id_i;
    logic [MATCH_BIT-1:0]     job_match_i;
    logic [MATCH_BIT-1:0]     job_mismatch_i;
    logic [MATCH_BIT-1:0]     job_alpha_i;
    logic [MATCH_BIT-1:0]     job_beta_i;
    logic                     sw_start_o;
    logic [MATCH_BIT-1:0]     sw_match_o;
    logic [MATCH_BIT-1:0]     sw_mismatch_o;
    logic [MATCH_BIT-1:0]     sw_alpha_o;
    logic [MATCH_BIT-1:0]     sw_beta_o;
    logic                     sw_busy_i;
    logic                     sw_valid_i;
    logic [CALC_BIT-1:0]      sw_result_i;
    logic [MAX_T_NUM_BIT-1:0] sw_match_idx_i;
    logic                     res_valid_o;
    logic                     res_ready_i;
    logic [SCHED_ID_BIT-1:0]  res_id_o;
    logic [CALC_BIT-1:0]      res_best_o;
    logic [MAX_T_NUM_BIT-1:0] res_idx_o;
    logic [CNT_BIT-1:0]       res_count_o;
    logic [1:0]               res_err_o;
    logic                     idle_o;

    modport slave (
        input  job_valid_i, job_id_i, job_match_i, job_mismatch_i, job_alpha_i, job_beta_i,
        input  sw_busy_i, sw_valid_i, sw_result_i, sw_match_idx_i, res_ready_i,
        output job_ready_o, sw_start_o, sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o,
        output res_valid_o, res_id_o, res_best_o, res_idx_o, res_count_o, res_err_o, idle_o
    );

    modport master (
        output job_valid_i, job_id_i, job_match_i, job_mismatch_i, job_alpha_i, job_beta_i,
        output sw_busy_i, sw_valid_i, sw_result_i, sw_match_idx_i, res_ready_i,
        input  job_ready_o, sw_start_o, sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o,
        input  res_valid_o, res_id_o, res_best_o, res_idx_o, res_count_o, res_err_o, idle_o
    );
endinterface

// File: rtl/sw_job_scheduler_reducer.sv
// sw_result_reducer: folds the core's streamed results into best score,
// index of the first best and a saturating result count.
// Ports: clk, rst_n; clr_i clears all state; en_i accepts one result
// (result_i, idx_i); best_o/idx_o/count_o are registered.
module sw_result_reducer
    import sw_job_scheduler_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic [CALC_BIT-1:0]      result_i,
    input  logic [MAX_T_NUM_BIT-1:0] idx_i,
    output logic [CALC_BIT-1:0]      best_o,
    output logic [MAX_T_NUM_BIT-1:0] idx_o,
    output logic [CNT_BIT-1:0]       count_o
);
    logic [CALC_BIT-1:0]      best_q, best_d;
    logic [MAX_T_NUM_BIT-1:0] idx_q, idx_d;
    logic [CNT_BIT-1:0]       count_q, count_d;
    logic                     better;

    // Strictly greater, so a tie keeps the earlier index.
    assign better = $signed(result_i) > $signed(best_q);

    always_comb begin
        best_d  = clr_i ? '0 : (en_i && better) ? result_i : best_q;
        idx_d   = clr_i ? '0 : (en_i && better) ? idx_i : idx_q;
        count_d = clr_i ? '0 : en_i ? sat_inc(count_q) : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            best_q  <= best_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign best_o  = best_q;
    assign idx_o   = idx_q;
    assign count_o = count_q;
endmodule

// File: rtl/sw_job_scheduler.sv
// sw_job_scheduler: accepts one alignment job at a time, starts the
// Smith-Waterman core with held parameters, watches busy, reduces results
// and returns one result record per job.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the job
// handshake, core start/parameter/busy/result signals and the result record.
module sw_job_scheduler
    import sw_job_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1048575,
    parameter int BUSY_WAIT   = 4
) (
    input  logic clk,
    input  logic rst_n,
    sw_job_scheduler_if.slave bus
);
    localparam int WW = $clog2(BUSY_WAIT + 1);

    state_e                  state_q;
    logic                    job_ready_q, idle_q, sw_start_q, res_valid_q;
    logic [SCHED_ID_BIT-1:0] id_q;
    logic [MATCH_BIT-1:0]    match_q, mismatch_q, alpha_q, beta_q;
    logic [1:0]              err_q;
    logic [WW-1:0]           wait_cnt_q;
    logic [19:0]             tcnt_q;
    logic                    accept;

    assign accept = bus.job_valid_i && job_ready_q;

    // Counters are compared after increment so the transition happens on
    // the last allowed cycle rather than one past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            job_ready_q <= 1'b1;
            idle_q      <= 1'b1;
            sw_start_q  <= 1'b0;
            res_valid_q <= 1'b0;
            id_q        <= '0;
            match_q     <= '0;
            mismatch_q  <= '0;
            alpha_q     <= '0;
            beta_q      <= '0;
            err_q       <= ERR_OK;
            wait_cnt_q  <= '0;
            tcnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    id_q        <= bus.job_id_i;
                    match_q     <= bus.job_match_i;
                    mismatch_q  <= bus.job_mismatch_i;
                    alpha_q     <= bus.job_alpha_i;
                    beta_q      <= bus.job_beta_i;
                    err_q       <= ERR_OK;
                    job_ready_q <= 1'b0;
                    idle_q      <= 1'b0;
                    sw_start_q  <= 1'b1;
                    state_q     <= START;
                end
                START: begin
                    sw_start_q <= 1'b0;
                    wait_cnt_q <= '0;
                    state_q    <= WAIT_BUSY;
                end
                WAIT_BUSY: if (bus.sw_busy_i) begin
                    tcnt_q  <= '0;
                    state_q <= RUN;
                end else if (wait_cnt_q + WW'(1) == WW'(BUSY_WAIT)) begin
                    err_q       <= ERR_NO_BUSY;
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end else begin
                    wait_cnt_q <= wait_cnt_q + WW'(1);
                end
                RUN: if (!bus.sw_busy_i) begin
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end else if (tcnt_q + 20'd1 == 20'(TIMEOUT_CYC)) begin
                    err_q       <= ERR_TIMEOUT;
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end else begin
                    tcnt_q <= tcnt_q + 20'd1;
                end
                DONE: if (bus.res_ready_i) begin
                    res_valid_q <= 1'b0;
                    job_ready_q <= 1'b1;
                    idle_q      <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sw_result_reducer u_reducer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q == IDLE && accept),
        .en_i     (state_q == RUN && bus.sw_valid_i),
        .result_i (bus.sw_result_i),
        .idx_i    (bus.sw_match_idx_i),
        .best_o   (bus.res_best_o),
        .idx_o    (bus.res_idx_o),
        .count_o  (bus.res_count_o)
    );

    assign bus.job_ready_o   = job_ready_q;
    assign bus.idle_o        = idle_q;
    assign bus.sw_start_o    = sw_start_q;
    assign bus.sw_match_o    = match_q;
    assign bus.sw_mismatch_o = mismatch_q;
    assign bus.sw_alpha_o    = alpha_q;
    assign bus.sw_beta_o     = beta_q;
    assign bus.res_valid_o   = res_valid_q;
    assign bus.res_id_o      = id_q;
    assign bus.res_err_o     = err_q;
endmodule
